// File: rtl/seg7_output_logic.sv
// Six-digit multiplexed hex display driver: 4 data digits, 2 PC digits and an LED bar, snapshotted once per frame.
// Outputs are registered, one cycle behind internal state. There is no flow control. BLANK_CYCLES >= DIV_MAX+1 is illegal because the digits never light.
module seg7_output_logic #(
  parameter int unsigned DIV_MAX      = 49999,
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_cpu,
  input  logic [15:0] output_port,
  input  logic [7:0]  PC_below8bit,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic [7:0]  led,
  output logic        frame_start
);

  localparam int unsigned BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES);
  localparam logic [DIV_WIDTH-1:0] DIV_TC = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [2:0]           index_q, index_d;
  logic                 first_q, first_d;
  logic [15:0]          snap_data_q, snap_data_d;
  logic [7:0]           snap_pc_q, snap_pc_d;
  logic [BW-1:0]        blank_q, blank_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [5:0]           an_q, an_d;
  logic [7:0]           led_q, led_d;
  logic                 frame_start_q, frame_start_d;

  logic       tick;
  logic       wrap;
  logic       load;
  logic [3:0] nib;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_comb begin
    tick = (prescaler_q == DIV_TC);
    wrap = tick && (index_q == 3'd5);
    // first_q forces a snapshot on the first edge after reset, so the display never shows stale zeros for a whole frame
    load = first_q || wrap;

    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    first_d     = 1'b0;

    index_d = index_q;
    if (tick) index_d = wrap ? 3'd0 : index_q + 3'd1;

    snap_data_d = snap_data_q;
    snap_pc_d   = snap_pc_q;
    if (load && !freeze) begin
      snap_data_d = output_port;
      snap_pc_d   = PC_below8bit;
    end

    blank_d = blank_q;
    if (tick)                blank_d = BLANK_INIT;
    else if (blank_q != '0)  blank_d = blank_q - 1'b1;

    case (index_q)
      3'd0:    nib = snap_data_q[3:0];
      3'd1:    nib = snap_data_q[7:4];
      3'd2:    nib = snap_data_q[11:8];
      3'd3:    nib = snap_data_q[15:12];
      3'd4:    nib = snap_pc_q[3:0];
      default: nib = snap_pc_q[7:4];
    endcase

    seg_d         = hex_decode(nib);
    dp_d          = (index_q != 3'd4);
    an_d          = (blank_q != '0) ? 6'h3F : ~(6'b000001 << index_q);
    led_d         = snap_pc_q;
    frame_start_d = load;
  end

  always_ff @(posedge clk or posedge reset_cpu) begin
    if (reset_cpu) begin
      prescaler_q   <= '0;
      index_q       <= 3'd0;
      first_q       <= 1'b1;
      snap_data_q   <= 16'h0000;
      snap_pc_q     <= 8'h00;
      blank_q       <= BLANK_INIT;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= 6'h3F;
      led_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      index_q       <= index_d;
      first_q       <= first_d;
      snap_data_q   <= snap_data_d;
      snap_pc_q     <= snap_pc_d;
      blank_q       <= blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      led_q         <= led_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign led         = led_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_output_logic.sv
// Bench for seg7_output_logic: DIV_MAX=3 with BLANK_CYCLES=1 (main) and BLANK_CYCLES=0 (second instance).
module tb_seg7_output_logic;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic [15:0] output_port;
  logic [7:0]  PC_below8bit;
  logic        freeze;

  logic [6:0] seg, nb_seg;
  logic       dp, nb_dp;
  logic [5:0] an, nb_an;
  logic [7:0] led, nb_led;
  logic       frame_start, nb_frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seg7_output_logic #(.DIV_MAX(3), .DIV_WIDTH(4), .BLANK_CYCLES(1)) u_dut (
    .clk(clk), .reset_cpu(reset_cpu), .output_port(output_port), .PC_below8bit(PC_below8bit),
    .freeze(freeze), .seg(seg), .dp(dp), .an(an), .led(led), .frame_start(frame_start)
  );

  seg7_output_logic #(.DIV_MAX(3), .DIV_WIDTH(4), .BLANK_CYCLES(0)) u_nb (
    .clk(clk), .reset_cpu(reset_cpu), .output_port(output_port), .PC_below8bit(PC_below8bit),
    .freeze(freeze), .seg(nb_seg), .dp(nb_dp), .an(nb_an), .led(nb_led), .frame_start(nb_frame_start)
  );

  function automatic logic [3:0] digit_of(input logic [15:0] d, input logic [7:0] p, input int idx);
    if (idx < 4) return d[4*idx +: 4];
    return p[4*(idx-4) +: 4];
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [7:0] p);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.an  = ~(6'b000001 << i);
      e.seg = HEX[digit_of(d, p, i)];
      e.dp  = (i != 4);
      sb.push_back(e);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Waits for the next digit to light after at least one all-off sample.
  task automatic next_digit(output logic [5:0] a, output logic [6:0] s, output logic d,
                            output int gap, output bit ok);
    logic [5:0] prev;
    prev = an; gap = 0; ok = 1'b0; a = '0; s = '0; d = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an == 6'h3F) gap++;
      else if (prev == 6'h3F) begin
        a = an; s = seg; d = dp; ok = 1'b1;
        return;
      end
      prev = an;
    end
  endtask

  task automatic test_reset;
    int pulses;
    @(negedge clk);
    reset_cpu = 1'b1;
    #1;
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL reset_an got %h want 3f", an); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got %b want 1", dp); end
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led got %h want 00", led); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", frame_start); end
    n_cmp++; if (nb_an !== 6'h3F) begin n_bad++; $display("FAIL reset_nb_an got %h want 3f", nb_an); end
    output_port  = 16'h1A8F;
    PC_below8bit = 8'h3C;
    @(negedge clk);
    reset_cpu = 1'b0;
    @(negedge clk);
    pulses = frame_start ? 1 : 0;
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL release_fs got %b want 1", frame_start); end
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL release_led_early got %h want 00", led); end
    @(negedge clk);
    n_cmp++; if (led !== 8'h3C) begin n_bad++; $display("FAIL release_led got %h want 3c", led); end
    if (frame_start) pulses++;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (frame_start) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL release_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_scan_order;
    bit ok; int gap; logic [5:0] a; logic [6:0] s; logic d; exp_t e;
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL scan_fs got timeout want pulse"); end
    push_frame(16'h1A8F, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      next_digit(a, s, d, gap, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || a !== e.an || s !== e.seg || d !== e.dp || gap != 1) begin
        n_bad++;
        $display("FAIL scan_d%0d got an=%h seg=%h dp=%b gap=%0d want an=%h seg=%h dp=%b gap=1",
                 i, a, s, d, gap, e.an, e.seg, e.dp);
      end
    end
    n_cmp++; if (led !== 8'h3C) begin n_bad++; $display("FAIL scan_led got %h want 3c", led); end
  endtask

  task automatic test_snapshot_isolation;
    bit ok; int gap; logic [5:0] a; logic [6:0] s; logic d; exp_t e;
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL iso_fs got timeout want pulse"); end
    push_frame(16'h1A8F, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) output_port = 16'h0000;
      next_digit(a, s, d, gap, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || a !== e.an || s !== e.seg) begin
        n_bad++;
        $display("FAIL iso_old_d%0d got an=%h seg=%h want an=%h seg=%h", i, a, s, e.an, e.seg);
      end
    end
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL iso_fs2 got timeout want pulse"); end
    push_frame(16'h0000, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      next_digit(a, s, d, gap, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || a !== e.an || s !== e.seg) begin
        n_bad++;
        $display("FAIL iso_new_d%0d got an=%h seg=%h want an=%h seg=%h", i, a, s, e.an, e.seg);
      end
    end
  endtask

  task automatic test_freeze;
    bit ok; int gap; logic [5:0] a; logic [6:0] s; logic d; exp_t e;
    freeze       = 1'b1;
    output_port  = 16'h2222;
    PC_below8bit = 8'h55;
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL frz_fs got timeout want pulse"); end
    push_frame(16'h0000, 8'h3C);
    for (int i = 0; i < 6; i++) begin
      next_digit(a, s, d, gap, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || a !== e.an || s !== e.seg) begin
        n_bad++;
        $display("FAIL frz_hold_d%0d got an=%h seg=%h want an=%h seg=%h", i, a, s, e.an, e.seg);
      end
    end
    n_cmp++; if (led !== 8'h3C) begin n_bad++; $display("FAIL frz_led got %h want 3c", led); end
    freeze = 1'b0;
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL unfrz_fs got timeout want pulse"); end
    push_frame(16'h2222, 8'h55);
    for (int i = 0; i < 6; i++) begin
      next_digit(a, s, d, gap, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || a !== e.an || s !== e.seg) begin
        n_bad++;
        $display("FAIL unfrz_d%0d got an=%h seg=%h want an=%h seg=%h", i, a, s, e.an, e.seg);
      end
    end
    n_cmp++; if (led !== 8'h55) begin n_bad++; $display("FAIL unfrz_led got %h want 55", led); end
  endtask

  task automatic test_no_blank;
    bit ok; int idx; int zeros; logic [6:0] want;
    output_port  = 16'h1A8F;
    PC_below8bit = 8'h3C;
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL nb_fs got timeout want pulse"); end
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      zeros = 0; idx = 0;
      for (int b = 0; b < 6; b++) if (nb_an[b] == 1'b0) begin zeros++; idx = b; end
      want = HEX[digit_of(16'h1A8F, 8'h3C, idx)];
      n_cmp++;
      if (zeros != 1 || nb_seg !== want || nb_dp !== (idx != 4)) begin
        n_bad++;
        $display("FAIL nb_cycle%0d got an=%h seg=%h dp=%b want one-hot an seg=%h dp=%b",
                 c, nb_an, nb_seg, nb_dp, want, (idx != 4));
      end
    end
  endtask

  task automatic test_period;
    bit ok; int n; int gap; int len; logic [5:0] a; logic [6:0] s; logic d;
    wait_fs(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL per_fs got timeout want pulse"); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 100);
    n_cmp++; if (n != 24) begin n_bad++; $display("FAIL per_frame got %0d want 24", n); end
    for (int k = 0; k < 2; k++) begin
      next_digit(a, s, d, gap, ok);
      len = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (an !== a) break;
        len++;
      end
      n_cmp++;
      if (!ok || len != 3) begin
        n_bad++;
        $display("FAIL per_an_low%0d got %0d want 3", k, len);
      end
    end
  endtask

  initial begin
    reset_cpu    = 1'b1;
    output_port  = 16'h5555;
    PC_below8bit = 8'hAA;
    freeze       = 1'b0;
    repeat (3) @(negedge clk);
    reset_cpu = 1'b0;
    repeat (10) @(negedge clk);
    test_reset;
    test_scan_order;
    test_snapshot_isolation;
    test_freeze;
    test_no_blank;
    test_period;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
